// File: rtl/axi_mem_responder_if.sv
// AXI-like memory bus bundle: AW/W/B write channels and AR/R read channels.
// The memory responder connects through the slave modport; a requester uses master.
interface axi_mem_responder_if #(
  parameter int EXT_ADDR_W = 40,
  parameter int DATA_WIDTH = 256
);
  logic [EXT_ADDR_W-1:0] axi_awaddr;
  logic [7:0]            axi_awlen;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [DATA_WIDTH-1:0] axi_wdata;
  logic                  axi_wlast;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic [EXT_ADDR_W-1:0] axi_araddr;
  logic [7:0]            axi_arlen;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awvalid,
    input  axi_wdata, axi_wlast, axi_wvalid,
    input  axi_bready,
    input  axi_araddr, axi_arlen, axi_arvalid,
    input  axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
    output axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport master (
    output axi_awaddr, axi_awlen, axi_awvalid,
    output axi_wdata, axi_wlast, axi_wvalid,
    output axi_bready,
    output axi_araddr, axi_arlen, axi_arvalid,
    output axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
    input  axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/axi_mem_responder.sv
// Single-burst AXI-like memory slave. One FSM serves either a write burst
// (AW, W beats, B) or a read burst (AR, optional latency, R beats) at a time.
// Address/len/range flags are shared between the two directions since only
// one burst is ever in flight. Memory contents survive reset.
module axi_mem_responder #(
  parameter int          EXT_ADDR_W  = 40,
  parameter int          DATA_WIDTH  = 256,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          RD_LATENCY  = 2
) (
  input logic               clk,
  input logic               rst,
  axi_mem_responder_if.slave s_axi
);
  localparam int OFFS  = $clog2(DATA_WIDTH/8);
  // two spare bits so base index + len can never wrap
  localparam int IDX_W = EXT_ADDR_W + 2;
  localparam int MA_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state_q;
  logic [MA_W-1:0]       base_q;
  logic [7:0]            len_q, beat_q;
  logic                  oor_q, werr_q;
  logic [3:0]            wait_q;
  logic                  bvalid_q, rvalid_q, rlast_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [EXT_ADDR_W-1:0] req_addr;
  logic [7:0]            req_len;
  logic [IDX_W-1:0]      req_idx, req_end;
  logic                  req_oor;
  logic                  aw_hs, ar_hs, w_hs;
  logic [7:0]            ld_beat, ld_len;
  logic [MA_W-1:0]       ld_addr;
  logic                  ld_oor, ld_en;

  assign s_axi.axi_awready = (state_q == IDLE) && !rst;
  assign s_axi.axi_arready = (state_q == IDLE) && !rst && !s_axi.axi_awvalid;
  assign s_axi.axi_wready  = (state_q == WR_DATA) && !rst;
  assign s_axi.axi_bvalid  = bvalid_q;
  assign s_axi.axi_bresp   = bresp_q;
  assign s_axi.axi_rvalid  = rvalid_q;
  assign s_axi.axi_rresp   = rresp_q;
  assign s_axi.axi_rlast   = rlast_q;
  assign s_axi.axi_rdata   = rdata_q;

  assign aw_hs = s_axi.axi_awready && s_axi.axi_awvalid;
  assign ar_hs = s_axi.axi_arready && s_axi.axi_arvalid;
  assign w_hs  = s_axi.axi_wready  && s_axi.axi_wvalid;

  // Decode the request being offered in IDLE: write side wins when both valid.
  always_comb begin
    req_addr = s_axi.axi_awvalid ? s_axi.axi_awaddr : s_axi.axi_araddr;
    req_len  = s_axi.axi_awvalid ? s_axi.axi_awlen  : s_axi.axi_arlen;
    req_idx  = (IDX_W'(req_addr) - IDX_W'(BASE_ADDR)) >> OFFS;
    req_end  = req_idx + IDX_W'(req_len);
    req_oor  = (IDX_W'(req_addr) < IDX_W'(BASE_ADDR)) ||
               (req_end >= IDX_W'(DEPTH_WORDS));
  end

  // Select which read beat gets loaded into the R output registers this edge.
  always_comb begin
    ld_beat = (state_q == RD_DATA) ? beat_q + 8'd1 : 8'd0;
    ld_len  = (state_q == IDLE) ? req_len : len_q;
    ld_oor  = (state_q == IDLE) ? req_oor : oor_q;
    ld_addr = ((state_q == IDLE) ? MA_W'(req_idx) : base_q) + MA_W'(ld_beat);
    ld_en   = ((state_q == IDLE) && ar_hs && (RD_LATENCY == 0)) ||
              ((state_q == RD_WAIT) && (wait_q == 4'd0)) ||
              ((state_q == RD_DATA) && s_axi.axi_rready && (beat_q != len_q));
  end

  // Backing store write port; out-of-range bursts are dropped, no reset.
  always_ff @(posedge clk) begin
    if (w_hs && !oor_q) mem[base_q + MA_W'(beat_q)] <= s_axi.axi_wdata;
  end

  // Burst FSM with registered B and R channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      oor_q    <= 1'b0;
      werr_q   <= 1'b0;
      wait_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs || ar_hs) begin
            base_q <= MA_W'(req_idx);
            len_q  <= req_len;
            oor_q  <= req_oor;
            beat_q <= 8'd0;
            werr_q <= 1'b0;
          end
          if (aw_hs) begin
            state_q <= WR_DATA;
          end else if (ar_hs) begin
            if (RD_LATENCY == 0) begin
              state_q  <= RD_DATA;
              rvalid_q <= 1'b1;
            end else begin
              state_q <= RD_WAIT;
              wait_q  <= 4'(RD_LATENCY - 1);
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (beat_q == len_q) begin
              state_q  <= WR_RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= (oor_q || werr_q || !s_axi.axi_wlast) ? 2'b10 : 2'b00;
            end else if (s_axi.axi_wlast) begin
              werr_q <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (s_axi.axi_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            state_q  <= IDLE;
          end
        end
        RD_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q  <= RD_DATA;
            rvalid_q <= 1'b1;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        RD_DATA: begin
          if (s_axi.axi_rready) begin
            if (beat_q == len_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (ld_en) begin
        rdata_q <= ld_oor ? '0 : mem[ld_addr];
        rresp_q <= ld_oor ? 2'b10 : 2'b00;
        rlast_q <= (ld_beat == ld_len);
      end
    end
  end
endmodule
